multicycle_control_unit: RTL and testbench

MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

---
 rtl/multicycle_control_unit.sv | 236 +++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multicycle RV32I control FSM: sequences fetch, decode,
// execute, memory and writeback phases over a shared datapath.
module multicycle_control_unit #(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit FULL_BRANCH   = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] instruction,
   input  logic        zero_flg,
   input  logic        lt_flg,
   input  logic        ltu_flg,
   input  logic        mem_ready,
   output logic        PCWrite,
   output logic        AdrSrc,
   output logic        MemRead,
   output logic        MemWrite,
   output logic        IRWrite,
   output logic [1:0]  ResultSrc,
   output logic [1:0]  ALUSrcA,
   output logic [1:0]  ALUSrcB,
   output logic [2:0]  ALUControl,
   output logic [1:0]  ImmSrc,
   output logic        RegWrite,
   output logic        illegal,
   output logic [3:0]  state_o
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMREAD  = 4'd3,
      MEMWB    = 4'd4,
      MEMWRITE = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      JAL      = 4'd9,
      BRANCH   = 4'd10,
      TRAP     = 4'd11
   } state_t;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_BR    = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   state_t      state, state_nxt;
   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic        is_ld, is_st, is_r, is_i, is_jal, is_br;
   logic        ready, alu_ok, br_ok, ls_ok, taken;
   logic [2:0]  alu_op;
   logic        pc_wr, ir_wr, mem_rd, mem_wr, reg_wr;
   logic        unused_bits;

   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign unused_bits = ^{instruction[31],
                          instruction[29:15],
                          instruction[11:7]};

   assign is_ld  = (opcode == OP_LOAD);
   assign is_st  = (opcode == OP_STORE);
   assign is_r   = (opcode == OP_R);
   assign is_i   = (opcode == OP_I);
   assign is_jal = (opcode == OP_JAL);
   assign is_br  = (opcode == OP_BR);

   assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign ls_ok = (funct3 == 3'b010);

   always_comb begin
      alu_op = ALU_ADD;
      alu_ok = 1'b1;
      case (funct3)
         3'b000: alu_op = (is_r && instruction[30]) ?
                          ALU_SUB : ALU_ADD;
         3'b010: alu_op = ALU_SLT;
         3'b100: alu_op = ALU_XOR;
         3'b110: alu_op = ALU_OR;
         3'b111: alu_op = ALU_AND;
         default: alu_ok = 1'b0;
      endcase
   end

   // Only beq/bne are legal in the reduced branch build
   always_comb begin
      taken = 1'b0;
      br_ok = FULL_BRANCH;
      case (funct3)
         3'b000: begin
            taken = zero_flg;
            br_ok = 1'b1;
         end
         3'b001: begin
            taken = !zero_flg;
            br_ok = 1'b1;
         end
         3'b100: taken = lt_flg;
         3'b101: taken = !lt_flg;
         3'b110: taken = ltu_flg;
         3'b111: taken = !ltu_flg;
         default: br_ok = 1'b0;
      endcase
   end

   always_comb begin
      ImmSrc = 2'b00;
      unique case (1'b1)
         is_st:   ImmSrc = 2'b01;
         is_br:   ImmSrc = 2'b10;
         is_jal:  ImmSrc = 2'b11;
         default: ImmSrc = 2'b00;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= FETCH;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      reg_wr     = 1'b0;
      AdrSrc     = 1'b0;
      ResultSrc  = 2'b00;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ALUControl = ALU_ADD;
      illegal    = 1'b0;
      case (state)
         FETCH: begin
            mem_rd    = 1'b1;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            ir_wr     = ready;
            pc_wr     = ready;
            if (ready) state_nxt = DECODE;
         end
         DECODE: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b01;
            unique case (1'b1)
               is_ld, is_st:
                  state_nxt = ls_ok ? MEMADR : TRAP;
               is_r:
                  state_nxt = alu_ok ? EXECUTER : TRAP;
               is_i:
                  state_nxt = alu_ok ? EXECUTEI : TRAP;
               is_jal:
                  state_nxt = JAL;
               is_br:
                  state_nxt = br_ok ? BRANCH : TRAP;
               default:
                  state_nxt = TRAP;
            endcase
         end
         MEMADR: begin
            ALUSrcA   = 2'b10;
            ALUSrcB   = 2'b01;
            state_nxt = is_st ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            AdrSrc = 1'b1;
            mem_rd = 1'b1;
            if (ready) state_nxt = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            reg_wr    = 1'b1;
            state_nxt = FETCH;
         end
         MEMWRITE: begin
            AdrSrc = 1'b1;
            mem_wr = 1'b1;
            if (ready) state_nxt = FETCH;
         end
         EXECUTER: begin
            ALUSrcA    = 2'b10;
            ALUControl = alu_op;
            state_nxt  = ALUWB;
         end
         EXECUTEI: begin
            ALUSrcA    = 2'b10;
            ALUSrcB    = 2'b01;
            ALUControl = alu_op;
            state_nxt  = ALUWB;
         end
         ALUWB: begin
            reg_wr    = 1'b1;
            state_nxt = FETCH;
         end
         // Target was parked in ALUOut by DECODE; ALU makes rd=OldPC+4
         JAL: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            pc_wr     = 1'b1;
            state_nxt = ALUWB;
         end
         BRANCH: begin
            ALUSrcA    = 2'b10;
            ALUControl = ALU_SUB;
            pc_wr      = taken;
            state_nxt  = FETCH;
         end
         TRAP: begin
            illegal = 1'b1;
         end
         default: state_nxt = TRAP;
      endcase
   end

   // Strobes drop combinationally with reset, even mid-access
   assign PCWrite  = pc_wr  & rst_n;
   assign IRWrite  = ir_wr  & rst_n;
   assign MemRead  = mem_rd & rst_n;
   assign MemWrite = mem_wr & rst_n;
   assign RegWrite = reg_wr & rst_n;
   assign state_o  = state;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit against a
// phase-list model of each instruction's execution path.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] instruction;
   logic        zero_flg, lt_flg, ltu_flg, mem_ready;
   logic        PCWrite, AdrSrc, MemRead, MemWrite, IRWrite;
   logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
   logic [2:0]  ALUControl;
   logic        RegWrite, illegal;
   logic [3:0]  state_o;

   logic        rst2_n;
   logic [31:0] instr2;
   logic        mem_ready_b;
   logic        PCWrite_b, AdrSrc_b, MemRead_b, MemWrite_b;
   logic        IRWrite_b, RegWrite_b, illegal_b;
   logic [1:0]  ResultSrc_b, ALUSrcA_b, ALUSrcB_b, ImmSrc_b;
   logic [2:0]  ALUControl_b;
   logic [3:0]  state_o_b;

   logic [17:0] got_ctrl;
   int          n_checks = 0;
   int          n_errors = 0;
   int          path[$];

   always #5 clk = ~clk;

   multicycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .instruction(instruction),
      .zero_flg(zero_flg), .lt_flg(lt_flg), .ltu_flg(ltu_flg),
      .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
      .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
      .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
      .ALUControl(ALUControl), .ImmSrc(ImmSrc),
      .RegWrite(RegWrite), .illegal(illegal), .state_o(state_o)
   );

   multicycle_control_unit #(
      .MEM_HANDSHAKE(1'b0),
      .FULL_BRANCH(1'b0)
   ) dut_b (
      .clk(clk), .rst_n(rst2_n), .instruction(instr2),
      .zero_flg(zero_flg), .lt_flg(lt_flg), .ltu_flg(ltu_flg),
      .mem_ready(mem_ready_b), .PCWrite(PCWrite_b),
      .AdrSrc(AdrSrc_b), .MemRead(MemRead_b),
      .MemWrite(MemWrite_b), .IRWrite(IRWrite_b),
      .ResultSrc(ResultSrc_b), .ALUSrcA(ALUSrcA_b),
      .ALUSrcB(ALUSrcB_b), .ALUControl(ALUControl_b),
      .ImmSrc(ImmSrc_b), .RegWrite(RegWrite_b),
      .illegal(illegal_b), .state_o(state_o_b)
   );

   assign got_ctrl = {PCWrite, AdrSrc, MemRead, MemWrite, IRWrite,
                      ResultSrc, ALUSrcA, ALUSrcB, ALUControl,
                      ImmSrc, RegWrite, illegal};

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic bit br_taken(input logic [2:0] f3,
                                   input bit z, input bit lt,
                                   input bit ltu);
      case (f3)
         3'd0: return z;
         3'd1: return !z;
         3'd4: return lt;
         3'd5: return !lt;
         3'd6: return ltu;
         3'd7: return !ltu;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [2:0] exp_aop(input logic [31:0] ins);
      case (ins[14:12])
         3'd0: return (ins[6:0] == 7'b0110011 && ins[30]) ? 3'd1 : 3'd0;
         3'd2: return 3'd5;
         3'd4: return 3'd4;
         3'd6: return 3'd3;
         3'd7: return 3'd2;
         default: return 3'd0;
      endcase
   endfunction

   function automatic logic [1:0] exp_imm(input logic [31:0] ins);
      case (ins[6:0])
         7'b0100011: return 2'd1;
         7'b1100011: return 2'd2;
         7'b1101111: return 2'd3;
         default:    return 2'd0;
      endcase
   endfunction

   // Expected control word per phase, straight from the output tables
   function automatic logic [17:0] exp_ctrl(input int st, input bit mr,
                                            input bit tk,
                                            input logic [2:0] aop,
                                            input logic [1:0] imm);
      logic pcw, adr, mrd, mwr, irw, rw, ill;
      logic [1:0] rs, sa, sb;
      logic [2:0] ac;
      pcw = 0; adr = 0; mrd = 0; mwr = 0; irw = 0; rw = 0; ill = 0;
      rs = 0; sa = 0; sb = 0; ac = 0;
      case (st)
         0:  begin mrd = 1; sb = 2; rs = 2; irw = mr; pcw = mr; end
         1:  begin sa = 1; sb = 1; end
         2:  begin sa = 2; sb = 1; end
         3:  begin adr = 1; mrd = 1; end
         4:  begin rs = 1; rw = 1; end
         5:  begin adr = 1; mwr = 1; end
         6:  begin sa = 2; ac = aop; end
         7:  begin sa = 2; sb = 1; ac = aop; end
         8:  rw = 1;
         9:  begin sa = 1; sb = 2; pcw = 1; end
         10: begin sa = 2; ac = 3'd1; pcw = tk; end
         11: ill = 1;
         default: ;
      endcase
      return {pcw, adr, mrd, mwr, irw, rs, sa, sb, ac, imm, rw, ill};
   endfunction

   task automatic build_path(input logic [31:0] ins, input bit fb);
      logic [2:0] f3;
      f3 = ins[14:12];
      path.delete();
      case (ins[6:0])
         7'b0110011, 7'b0010011:
            if (f3 inside {3'd0, 3'd2, 3'd4, 3'd6, 3'd7})
               path = '{0, 1, (ins[5] ? 6 : 7), 8};
            else path = '{0, 1, 11};
         7'b0000011:
            path = (f3 == 3'd2) ? '{0, 1, 2, 3, 4} : '{0, 1, 11};
         7'b0100011:
            path = (f3 == 3'd2) ? '{0, 1, 2, 5} : '{0, 1, 11};
         7'b1101111: path = '{0, 1, 9, 8};
         7'b1100011:
            if (f3 inside {3'd0, 3'd1} ||
                (fb && f3 inside {3'd4, 3'd5, 3'd6, 3'd7}))
               path = '{0, 1, 10};
            else path = '{0, 1, 11};
         default: path = '{0, 1, 11};
      endcase
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #1;
      chk("rst_state", 32'(state_o), 32'd0);
      chk("rst_strobes", 32'({PCWrite, IRWrite, MemRead, MemWrite,
                              RegWrite, illegal}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // lows < 0: random mem_ready; else that many stall cycles in MEMREAD/MEMWRITE
   task automatic run_main(input logic [31:0] ins, input int lows);
      int st;
      bit mr, tk;
      instruction = ins;
      build_path(ins, 1'b1);
      while (path.size() > 0) begin
         st = path[0];
         if (lows < 0) mr = ($urandom_range(0, 2) != 0);
         else if ((st == 3 || st == 5) && lows > 0) begin
            mr = 1'b0;
            lows--;
         end else mr = 1'b1;
         mem_ready = mr;
         zero_flg  = 1'($urandom_range(0, 1));
         lt_flg    = 1'($urandom_range(0, 1));
         ltu_flg   = 1'($urandom_range(0, 1));
         tk = br_taken(ins[14:12], zero_flg, lt_flg, ltu_flg);
         #1;
         chk("state", 32'(state_o), 32'(st));
         chk("ctrl", 32'(got_ctrl),
             32'(exp_ctrl(st, mr, tk, exp_aop(ins), exp_imm(ins))));
         if (st == 11) begin
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               mem_ready = 1'($urandom_range(0, 1));
               #1;
               chk("trap_state", 32'(state_o), 32'd11);
               chk("trap_ctrl", 32'(got_ctrl),
                   32'(exp_ctrl(11, 0, 0, 0, exp_imm(ins))));
            end
            do_reset();
            path.delete();
         end else begin
            if (!((st == 0 || st == 3 || st == 5) && !mr))
               void'(path.pop_front());
            @(negedge clk);
         end
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] ins;
      logic [2:0] f3;
      int k;
      int j;
      ins = $urandom;
      k = $urandom_range(0, 11);
      j = $urandom_range(0, 4);
      case (j)
         0: f3 = 3'd0;
         1: f3 = 3'd2;
         2: f3 = 3'd4;
         3: f3 = 3'd6;
         default: f3 = 3'd7;
      endcase
      case (k)
         0, 1: begin
            ins[6:0] = 7'b0110011;
            ins[31:25] = {1'b0, ins[30], 5'b0};
         end
         2, 3: ins[6:0] = 7'b0010011;
         4: begin ins[6:0] = 7'b0000011; f3 = 3'd2; end
         5: begin ins[6:0] = 7'b0100011; f3 = 3'd2; end
         6, 7: begin
            ins[6:0] = 7'b1100011;
            f3 = ins[14:12];
            if (f3 inside {3'd2, 3'd3}) f3 = f3 + 3'd2;
         end
         8: begin ins[6:0] = 7'b1101111; f3 = ins[14:12]; end
         9: begin
            ins[6:0] = ins[12] ? 7'b0110011 : 7'b0010011;
            f3 = {ins[13], ins[14], 1'b1} & 3'b101;
         end
         10: begin
            ins[6:0] = ins[13] ? 7'b0000011 : 7'b0100011;
            f3 = ins[14:12];
            if (f3 == 3'd2) f3 = 3'd0;
         end
         default: begin
            case (ins[9:8])
               2'd0: ins[6:0] = 7'b0110111;
               2'd1: ins[6:0] = 7'b0010111;
               2'd2: ins[6:0] = 7'b1100111;
               default: ins[6:0] = 7'b1110011;
            endcase
            f3 = ins[14:12];
         end
      endcase
      ins[14:12] = f3;
      return ins;
   endfunction

   task automatic lat_b(input logic [31:0] ins, input int exp_n,
                        input string tag);
      int n;
      n = 0;
      instr2 = ins;
      #1;
      chk("b_fetch_irw", 32'({state_o_b, IRWrite_b, PCWrite_b}),
          32'({4'd0, 1'b1, 1'b1}));
      do begin
         @(negedge clk);
         #1;
         n++;
      end while (state_o_b != 4'd0 && n < 20);
      chk(tag, 32'(n), 32'(exp_n));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n = 1'b0;
      rst2_n = 1'b0;
      instruction = 32'h0;
      instr2 = 32'h0;
      zero_flg = 1'b0;
      lt_flg = 1'b0;
      ltu_flg = 1'b0;
      mem_ready = 1'b1;
      mem_ready_b = 1'b0;
      @(negedge clk);
      #1;
      chk("reset_state", 32'(state_o), 32'd0);
      chk("reset_ctrl", 32'({PCWrite, IRWrite, MemRead, MemWrite,
                             RegWrite, illegal}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_main(32'h002081B3, 0);
      run_main(32'h402081B3, 0);
      run_main(32'h402091B3, 0);
      run_main(32'h0000A183, 3);
      run_main(32'h0020A023, 2);
      run_main(32'h00208063, -1);
      run_main(32'h00209063, -1);
      run_main(32'h008000EF, 0);

      // Reset in the middle of a stalled store
      instruction = 32'h0020A023;
      mem_ready = 1'b1;
      repeat (3) @(negedge clk);
      mem_ready = 1'b0;
      #1;
      chk("sw_wait_state", 32'(state_o), 32'd5);
      chk("sw_wait_mw", 32'(MemWrite), 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("sw_abort_mw", 32'(MemWrite), 32'd0);
      chk("sw_abort_state", 32'(state_o), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("sw_release_state", 32'(state_o), 32'd0);
      @(negedge clk);

      for (int i = 0; i < 300; i++) run_main(rand_instr(), -1);

      @(negedge clk);
      rst2_n = 1'b1;
      lat_b(32'h002081B3, 4, "b_lat_r");
      lat_b(32'h00508093, 4, "b_lat_i");
      lat_b(32'h0000A183, 5, "b_lat_lw");
      lat_b(32'h0020A023, 4, "b_lat_sw");
      lat_b(32'h00208063, 3, "b_lat_beq");
      lat_b(32'h00209063, 3, "b_lat_bne");
      lat_b(32'h008000EF, 4, "b_lat_jal");
      instr2 = 32'h0020D063;
      lt_flg = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      chk("b_bge_trap", 32'({state_o_b, illegal_b}),
          32'({4'd11, 1'b1}));
      repeat (3) @(negedge clk);
      #1;
      chk("b_bge_hold", 32'({state_o_b, illegal_b}),
          32'({4'd11, 1'b1}));

      $display("Simulation finished: %0d checks, %0d errors",
               n_checks, n_errors);
      $finish;
   end

endmodule
